// File: rtl/lisa_uart_pkg.sv
// Shared definitions for the LISA parametrised UART receiver and transmitter:
// receiver FSM states, parity modes and the 3-sample majority vote.
package lisa_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PAR,
        ST_STOP,
        ST_BREAK
    } rx_state_e;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/lisa_sync_fifo.sv
// First-word fall-through synchronous FIFO with level/full/empty status.
// A write into a full FIFO is accepted only when a read happens in the same cycle.
module lisa_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty,
    output logic                     wr_drop
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_wr, do_rd;

    always_comb begin
        level    = wr_ptr_q - rd_ptr_q;
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (level == (AW+1)'(DEPTH));
        do_rd    = rd_en & ~empty;
        do_wr    = wr_en & (~full | do_rd);
        wr_drop  = wr_en & ~do_wr;
        wr_ptr_d = wr_ptr_q + (AW+1)'(do_wr);
        rd_ptr_d = rd_ptr_q + (AW+1)'(do_rd);
        mem_d    = mem_q;
        if (do_wr) begin
            mem_d[wr_ptr_q[AW-1:0]] = wr_data;
        end
        rd_data  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/lisa_uart_rxn.sv
// Parametrised UART receiver: 16x oversampling with majority vote at mid-bit,
// optional parity, 1/2 stop bits, sticky error flags and an FWFT receive FIFO.
module lisa_uart_rxn
    import lisa_uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          baud_ref,
    input  logic                          rxd,
    input  logic                          rd,
    output logic [DATA_BITS-1:0]          d,
    output logic                          data_avail,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overrun,
    input  logic                          clr_err
);
    logic                 rxd_s1_q, rxd_s2_q;
    rx_state_e            state_q, state_d;
    logic [3:0]           tick_q, tick_d;
    logic [1:0]           hist_q, hist_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
    logic                 mid_sample, sample;
    logic                 push, par_bad, stop_bad;
    logic                 fifo_drop, fifo_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_s1_q <= 1'b1;
            rxd_s2_q <= 1'b1;
        end else begin
            rxd_s1_q <= rxd;
            rxd_s2_q <= rxd_s1_q;
        end
    end

    // tick_q == 8 on a tick is position 9 of the bit; hist_q holds the two prior ticks' samples.
    always_comb begin
        mid_sample = baud_ref & (tick_q == 4'd8);
        sample     = majority3(hist_q[1], hist_q[0], rxd_s2_q);
    end

    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        hist_d   = hist_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        push     = 1'b0;
        par_bad  = 1'b0;
        stop_bad = 1'b0;
        if (baud_ref) begin
            tick_d = tick_q + 4'd1;
            hist_d = {hist_q[0], rxd_s2_q};
        end
        unique case (state_q)
            ST_IDLE: begin
                if (baud_ref && !rxd_s2_q) begin
                    state_d = ST_START;
                    tick_d  = '0;
                end
            end
            ST_START: begin
                if (mid_sample) begin
                    state_d = sample ? ST_IDLE : ST_DATA;
                    bit_d   = '0;
                end
            end
            ST_DATA: begin
                if (mid_sample) begin
                    shift_d = {sample, shift_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + 4'd1;
                    if (bit_q == 4'(DATA_BITS-1)) begin
                        bit_d   = '0;
                        state_d = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
                    end
                end
            end
            ST_PAR: begin
                if (mid_sample) begin
                    par_bad = (PARITY == PAR_EVEN) ? ((^shift_q) != sample)
                                                   : ((^shift_q) == sample);
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (mid_sample) begin
                    if (!sample) begin
                        stop_bad = 1'b1;
                        state_d  = ST_BREAK;
                    end else if (bit_q == 4'(STOP_BITS-1)) begin
                        push    = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            ST_BREAK: begin
                if (rxd_s2_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        parity_err_d = (parity_err_q & ~clr_err) | par_bad;
        frame_err_d  = (frame_err_q  & ~clr_err) | stop_bad;
        overrun_d    = (overrun_q    & ~clr_err) | fifo_drop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            tick_q       <= '0;
            hist_q       <= '1;
            bit_q        <= '0;
            shift_q      <= '0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_d;
            hist_q       <= hist_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    lisa_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push),
        .wr_data (shift_q),
        .rd_en   (rd),
        .rd_data (d),
        .level   (fifo_level),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .wr_drop (fifo_drop)
    );

    always_comb begin
        data_avail = ~fifo_empty;
        parity_err = parity_err_q;
        frame_err  = frame_err_q;
        overrun    = overrun_q;
    end

endmodule

// File: doc/lisa_uart_rxn.md
# lisa_uart_rxn

Parametrised UART receiver with an integrated receive FIFO. It is the next generation of the fixed 8N1 `lisa_rx8n` receiver and serves both the LISA-lite test harness and on-chip debug ports. It adds configurable word width, parity, stop bits and FIFO depth, majority-vote sampling, and sticky error reporting. It shares the `baud_ref` tick produced by the `debug_brg` baud-rate generator.

## Interface
Parameters:
- `DATA_BITS`, 8: payload bits per frame; legal range 5..9.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 4: power of two, at least 2.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: reset. One clock; reset is asynchronous and active-low.
- `baud_ref` in 1: one-`clk` pulse at 16× the bit rate.
- `rxd` in 1: serial input, asynchronous, idle high.
- `rd` in 1: pop strobe, one `clk` per word.
- `d` out DATA_BITS: FIFO head word (first-word fall-through), valid while `data_avail`.
- `data_avail` out 1: FIFO not empty.
- `fifo_full` out 1: FIFO holds FIFO_DEPTH words.
- `fifo_level` out $clog2(FIFO_DEPTH)+1: number of words held.
- `parity_err` out 1: sticky flag.
- `frame_err` out 1: sticky flag.
- `overrun` out 1: sticky flag.
- `clr_err` in 1: clears all three sticky flags.

## Operation
- `rxd` passes through a 2-FF synchroniser; both flops reset to 1.
- FSM states: IDLE, START, DATA, PAR, STOP, BREAK. A 4-bit tick counter advances only on `baud_ref`.
- **IDLE:** a `baud_ref` tick with synced `rxd`=0 moves to START and clears the counter.
- **START:** at tick 8, majority of samples 7/8/9 is read.
  - Majority 1 (glitch): return to IDLE, no flags set.
  - Majority 0: go to DATA.
- **DATA:** one bit per 16 ticks, sampled by majority at 7/8/9, LSB first, for DATA_BITS bits. Then go to PAR if PARITY≠0, otherwise STOP.
- **PAR:** the sampled parity bit is checked against the data.
  - Mismatch: set `parity_err`. The word is still pushed.
- **STOP:** each stop bit is sampled at mid-bit.
  - Any stop bit sampled 0: set `frame_err`, discard the word, go to BREAK.
  - All stop bits good: push the word and return to IDLE at the mid-point of the last stop bit (a half bit early, to allow resynchronisation).
- **BREAK:** wait until synced `rxd`=1, then go to IDLE.
- **FIFO push when full:** the word is dropped, `overrun` is set, and the FIFO contents are unchanged.
- **`rd` when empty:** ignored.
- **Push and pop in the same cycle:**
  - Level is unchanged.
  - If the FIFO was full, the push succeeds and `overrun` is not set.
- **`clr_err`:** clears all three flags. If `clr_err` coincides with a new error event on a flag, set wins.

## Timing
- **Reset values:** `data_avail`, `fifo_full`, `fifo_level`, all error flags = 0; `d` = 0; FSM in IDLE; FIFO pointers = 0.
- **Reset mid-frame:** the partial word is abandoned with no push and no flag. The next frame after release must be received correctly.
- **Push latency:** `data_avail`, `fifo_level` and `d` update on the `clk` edge after the `baud_ref` tick that samples the final stop bit.
- **Pop:** `rd` high at edge N gives the next word on `d` and a decremented level after edge N.
- **Error flags:** assert on the `clk` following the detecting sample.
- **Frame latency:** from the falling edge of `rxd` to `data_avail` is (1 + DATA_BITS + (PARITY≠0) + STOP_BITS − 0.5) × 16 ticks, plus up to one tick of start-detect jitter, plus 3 `clk`.
- **Parity arithmetic:** computed over DATA_BITS only. Even parity: XOR of data bits equals the parity bit. Odd parity: XOR equals the inverted parity bit.

## Structure
- **`lisa_uart_pkg`:** FSM state enum, parity-mode localparams (`PAR_NONE`, `PAR_ODD`, `PAR_EVEN`), and the majority-vote function. This package is shared with the planned parametrised transmitter `lisa_uart_txn`.
- **`lisa_sync_fifo`:** one sub-module, with parameters WIDTH and DEPTH.
  - First-word fall-through.
  - Pointers one bit wider than the address.
  - Outputs: level, full, empty.

## Test plan
- **8N1 basic:** `baud_div`=81, send 0xA5. Expect `data_avail`=1, `d`=0xA5, `fifo_level`=1. Pulse `rd`: expect level 0 and `data_avail`=0.
- **7E1 parity:** send 0x3C with correct parity. Expect `d`=0x3C and `parity_err`=0. Resend with the parity bit inverted. Expect `parity_err`=1, the word is pushed, and `clr_err` clears the flag.
- **Framing error:** 8N1 frame of 0x55 with the stop bit driven 0 and held low for 3 bit times. Expect `frame_err`=1, level unchanged, no push until `rxd` rises. The next frame, 0x12, is received correctly.
- **Overrun:** FIFO_DEPTH=4, send 0x01..0x05 without `rd`. Expect `fifo_full`=1 after the 4th word and `overrun`=1 after the 5th; reads return 0x01..0x04. In a second run, pulse `rd` in the same cycle as the 5th push: `overrun` stays 0.
- **Glitch rejection:** drive `rxd` low for 4 `baud_ref` ticks. Expect no push, no flags, FSM in IDLE.
- **Reset mid-frame:** assert `rst_n` low during data bit 3 of 0xC3. All outputs are 0 immediately. After release, send 0x7E: expect `d`=0x7E and `fifo_level`=1.
